calc1_port_driver: RTL
======================

# calc1_port_driver

Single-port request initiator for the calc1 four-port calculator. Accepts operand transactions from the testbench/stimulus side into a small FIFO and drives them onto one calc1 port using the two-cycle command/data protocol (cmd+operand1, then operand2). It then waits for the port's response, applies a timeout, and returns the captured result with its tag. One instance sits in front of each calc1 port. Exactly one command is outstanding per port.

## Interface
- DEPTH, 4: pending-transaction FIFO entries (power of two, ≥2)
- TIMEOUT, 64: max cycles in WAIT before reporting a timeout (≥4)

- c_clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- txn_valid  in  1  new transaction offered
- txn_ready  out  1  FIFO can accept (= not full)
- txn_cmd  in  4  calc1 command (1 add, 2 sub, 5 lsh, 6 rsh; others forwarded unchanged)
- txn_op1  in  32  first operand
- txn_op2  in  32  second operand
- txn_tag  in  2  caller tag, echoed on response
- req_cmd_out  out  4  to calc1 req_cmd_in[n]
- req_data_out  out  32  to calc1 req_data_in[n]
- out_resp  in  2  from calc1 out_resp[n] (0 none, 1 success, 2 invalid/overflow, 3 internal error)
- out_data  in  32  from calc1 out_data[n]
- rsp_valid  out  1  one-cycle pulse: result available
- rsp_resp  out  2  captured out_resp (0 on timeout)
- rsp_data  out  32  captured out_data (0 on timeout)
- rsp_tag  out  2  tag of completed transaction
- rsp_timeout  out  1  qualifies rsp_valid: no response within TIMEOUT
- spurious_err  out  1  sticky: out_resp≠0 seen outside WAIT
- busy  out  1  state≠IDLE or FIFO non-empty

## Operation
- Push when txn_valid && txn_ready. txn_cmd=0 is accepted but discarded (not enqueued, no response).
- FIFO: DEPTH entries {cmd, op1, op2, tag}; push visible to FSM the cycle after the push edge.
- FSM states: IDLE, CMD, DATA, WAIT.
  - IDLE: FIFO non-empty → pop head into working registers, go CMD. Else stay.
  - CMD: req_cmd_out=cmd, req_data_out=op1; go DATA.
  - DATA: req_cmd_out=0, req_data_out=op2; clear wait counter; go WAIT.
  - WAIT: req_cmd_out=0, req_data_out=0; counter increments each cycle starting at 1. out_resp≠0 → capture resp/data/tag, rsp_valid=1, go IDLE. Else counter==TIMEOUT → rsp_valid=1, rsp_timeout=1, rsp_resp=0, rsp_data=0, go IDLE.
- Response on the same cycle the counter reaches TIMEOUT: response wins, rsp_timeout=0.
- out_resp≠0 in IDLE, CMD or DATA: set spurious_err (held until reset); the value is otherwise ignored.
- Operands/commands forwarded verbatim; driver performs no arithmetic or checking of results.
- Full FIFO: txn_ready=0; an offered transaction is held by the caller, never dropped. A pop and a push on the same edge are both honoured.

## Timing
- Reset (reset=0 at a rising edge): next cycle, state=IDLE, FIFO empty, req_cmd_out=0, req_data_out=0, rsp_valid=0, rsp_resp=0, rsp_data=0, rsp_tag=0, rsp_timeout=0, spurious_err=0, busy=0, txn_ready=1. Mid-transaction reset abandons the command; no response is reported.
- All outputs registered. Push at edge t into an empty idle block → pop at t+1, req_cmd_out=cmd during t+2, op2 during t+3, WAIT from t+4.
- Response sampled at edge r → rsp_valid high for exactly the cycle after r; earliest next command cycle is r+2 (one IDLE cycle).
- rsp_* fields hold their values until the next rsp_valid; they are valid only when rsp_valid=1.
- req_cmd_out is non-zero for exactly one cycle per command.

## Test plan
- Add: push {1, 0x0000_0005, 0x0000_0003, tag 2}; model responds resp=1, data=8 four cycles after DATA → cmd=1/data=5 then cmd=0/data=3 on consecutive cycles; one rsp_valid with resp=1, data=8, tag=2.
- Back-to-back: push 4 transactions (tags 0–3) in consecutive cycles with a model answering after 3 cycles → txn_ready stays high, 4 responses in tag order 0,1,2,3, each command starts exactly 2 cycles after the previous response.
- Full FIFO: stall responses, push DEPTH+2 transactions → txn_ready drops after DEPTH+1 accepted (one in flight + DEPTH queued); no transaction lost; all responses arrive once the model resumes.
- Timeout: never drive out_resp → rsp_valid with rsp_timeout=1, resp=0, data=0 exactly TIMEOUT cycles after WAIT entry; response at cycle TIMEOUT instead → rsp_timeout=0.
- Spurious/discard: push txn_cmd=0 → nothing on req_cmd_out, no response; drive out_resp=1 while IDLE → spurious_err=1 until reset.
- Reset mid-WAIT: assert reset=0 for one cycle with 2 queued entries → all outputs at reset values, busy=0, no rsp_valid, later out_resp ignored except setting spurious_err.

Source files
------------

// File: rtl/calc1_port_driver.sv
// calc1_port_driver: single-port request initiator for one calc1 port.
// Queues operand transactions in a small FIFO, issues each one as a two-cycle
// command/data sequence, then waits for the port response or a timeout and
// reports the captured result together with the caller's tag.
module calc1_port_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        c_clk,
    input  logic        reset,
    input  logic        txn_valid,
    output logic        txn_ready,
    input  logic [3:0]  txn_cmd,
    input  logic [31:0] txn_op1,
    input  logic [31:0] txn_op2,
    input  logic [1:0]  txn_tag,
    output logic [3:0]  req_cmd_out,
    output logic [31:0] req_data_out,
    input  logic [1:0]  out_resp,
    input  logic [31:0] out_data,
    output logic        rsp_valid,
    output logic [1:0]  rsp_resp,
    output logic [31:0] rsp_data,
    output logic [1:0]  rsp_tag,
    output logic        rsp_timeout,
    output logic        spurious_err,
    output logic        busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA, WAIT} state_t;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  tag;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head;
    entry_t        work_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg, count_next;
    state_t        state_reg, state_next;
    logic [TW-1:0] wait_cnt_reg, wait_cnt_next;

    logic          push;
    logic          pop;

    logic          txn_ready_reg;
    logic [3:0]    req_cmd_reg, req_cmd_next;
    logic [31:0]   req_data_reg, req_data_next;
    logic          rsp_valid_reg, rsp_valid_next;
    logic [1:0]    rsp_resp_reg, rsp_resp_next;
    logic [31:0]   rsp_data_reg, rsp_data_next;
    logic [1:0]    rsp_tag_reg, rsp_tag_next;
    logic          rsp_timeout_reg, rsp_timeout_next;
    logic          spurious_reg;
    logic          busy_reg;

    // A zero command completes the handshake but is never queued.
    assign push = txn_valid && txn_ready_reg && (txn_cmd != 4'd0);
    assign pop  = (state_reg == IDLE) && (count_reg != '0);
    assign head = mem[rd_ptr_reg];

    // FIFO storage; no reset needed since occupancy is tracked by count_reg.
    always_ff @(posedge c_clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {txn_cmd, txn_op1, txn_op2, txn_tag};
        end
    end

    // FIFO occupancy after this edge, honouring a simultaneous push and pop.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Next state and next registered outputs; outputs follow the state being entered.
    always_comb begin
        state_next       = state_reg;
        wait_cnt_next    = wait_cnt_reg;
        req_cmd_next     = 4'd0;
        req_data_next    = 32'd0;
        rsp_valid_next   = 1'b0;
        rsp_resp_next    = rsp_resp_reg;
        rsp_data_next    = rsp_data_reg;
        rsp_tag_next     = rsp_tag_reg;
        rsp_timeout_next = rsp_timeout_reg;
        case (state_reg)
            IDLE: begin
                if (pop) begin
                    state_next    = CMD;
                    req_cmd_next  = head.cmd;
                    req_data_next = head.op1;
                end
            end
            CMD: begin
                state_next    = DATA;
                req_data_next = work_reg.op2;
            end
            DATA: begin
                // Counter holds the index of the current WAIT cycle, first one is 1.
                state_next    = WAIT;
                wait_cnt_next = TW'(1);
            end
            WAIT: begin
                if (out_resp != 2'd0) begin
                    state_next       = IDLE;
                    rsp_valid_next   = 1'b1;
                    rsp_resp_next    = out_resp;
                    rsp_data_next    = out_data;
                    rsp_tag_next     = work_reg.tag;
                    rsp_timeout_next = 1'b0;
                end else if (wait_cnt_reg == TW'(TIMEOUT)) begin
                    state_next       = IDLE;
                    rsp_valid_next   = 1'b1;
                    rsp_resp_next    = 2'd0;
                    rsp_data_next    = 32'd0;
                    rsp_tag_next     = work_reg.tag;
                    rsp_timeout_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg + TW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, FIFO pointers, working entry and all registered outputs.
    always_ff @(posedge c_clk) begin
        if (!reset) begin
            state_reg       <= IDLE;
            wr_ptr_reg      <= '0;
            rd_ptr_reg      <= '0;
            count_reg       <= '0;
            wait_cnt_reg    <= '0;
            work_reg        <= '0;
            txn_ready_reg   <= 1'b1;
            req_cmd_reg     <= 4'd0;
            req_data_reg    <= 32'd0;
            rsp_valid_reg   <= 1'b0;
            rsp_resp_reg    <= 2'd0;
            rsp_data_reg    <= 32'd0;
            rsp_tag_reg     <= 2'd0;
            rsp_timeout_reg <= 1'b0;
            spurious_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            count_reg       <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
                work_reg   <= head;
            end
            txn_ready_reg   <= (count_next != CW'(DEPTH));
            req_cmd_reg     <= req_cmd_next;
            req_data_reg    <= req_data_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_resp_reg    <= rsp_resp_next;
            rsp_data_reg    <= rsp_data_next;
            rsp_tag_reg     <= rsp_tag_next;
            rsp_timeout_reg <= rsp_timeout_next;
            // A response while no command is awaiting one is flagged until reset.
            if ((state_reg != WAIT) && (out_resp != 2'd0)) begin
                spurious_reg <= 1'b1;
            end
            busy_reg        <= (state_next != IDLE) || (count_next != '0);
        end
    end

    assign txn_ready    = txn_ready_reg;
    assign req_cmd_out  = req_cmd_reg;
    assign req_data_out = req_data_reg;
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_resp     = rsp_resp_reg;
    assign rsp_data     = rsp_data_reg;
    assign rsp_tag      = rsp_tag_reg;
    assign rsp_timeout  = rsp_timeout_reg;
    assign spurious_err = spurious_reg;
    assign busy         = busy_reg;

endmodule
